// File: rtl/pipe_pkg.sv
// Shared types and per-stage default widths for the pipeline-stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_e;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 138;
  localparam int IDEX_CTRL_W  = 9;
  localparam int EXMEM_DATA_W = 107;
  localparam int EXMEM_CTRL_W = 5;
  localparam int MEMWB_DATA_W = 71;
  localparam int MEMWB_CTRL_W = 2;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with increment enable; sticks at all-ones until reset.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/r_pipe_stage.sv
// Configurable pipeline-stage register with valid/ready handshake, flush-to-bubble,
// optional skid entry for a registered ready, and a saturating bubble counter.
module r_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 9,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_xfer;
  logic              out_xfer;

  assign o_valid  = (state_q != ST_EMPTY);
  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = o_valid & i_ready;

  // Flush wins over every transfer; the skid entry always refills main before new input.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d     = ST_FULL;
            main_data_d = i_data;
            main_ctrl_d = i_ctrl;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_data_d = i_data;
            main_ctrl_d = i_ctrl;
          end else if (in_xfer) begin
            state_d = ST_SKID;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state_d     = ST_FULL;
            main_data_d = skid_data;
            main_ctrl_d = skid_ctrl;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data_q;
      logic [CTRL_W-1:0] skid_ctrl_q;
      logic              ready_q;
      logic              skid_load;

      assign skid_load = (state_q == ST_FULL) & in_xfer & ~out_xfer & ~i_flush;

      // Ready is registered from the next state so upstream never sees a comb path.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
          ready_q     <= 1'b1;
        end else begin
          if (skid_load) begin
            skid_data_q <= i_data;
            skid_ctrl_q <= i_ctrl;
          end
          ready_q <= (state_d != ST_SKID);
        end
      end

      assign skid_data = skid_data_q;
      assign skid_ctrl = skid_ctrl_q;
      assign o_ready   = ready_q;
    end else begin : g_noskid
      assign skid_data = '0;
      assign skid_ctrl = '0;
      assign o_ready   = i_ready | ~o_valid;
    end
  endgenerate

  assign o_data = main_data_q;
  assign o_ctrl = o_valid ? main_ctrl_q : '0;

  pipe_sat_cnt #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en (i_ready & ~o_valid),
    .o_cnt(o_bubble_cnt)
  );

endmodule
